// File: rtl/fma_share_arbiter.sv
// Round-robin front end that shares one pipelined FP32 FMA core between NUM_REQ engines.
// A tag rides alongside each issue so the returning result lands in the issuer's holding register.
module fma_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 3,
    parameter int TAG_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ*32-1:0]   req_c,
    output logic                    fma_in_valid,
    output logic [31:0]             fma_a,
    output logic [31:0]             fma_b,
    output logic [31:0]             fma_c,
    input  logic [31:0]             fma_result,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [NUM_REQ*32-1:0]   resp_data
);

    localparam int DATA_W = 32;
    localparam logic [TAG_W:0] NUM_REQ_W = (TAG_W+1)'(NUM_REQ);

    function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] base,
                                                  input logic [TAG_W:0]   ofs);
        logic [TAG_W:0] sum;
        sum = {1'b0, base} + ofs;
        if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
        return sum[TAG_W-1:0];
    endfunction

    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] eligible;
    logic [TAG_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   cand;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any;
    logic               vld_p0;
    logic [TAG_W-1:0]   tag_p0;
    logic               cap_vld;
    logic [TAG_W-1:0]   cap_tag;

    assign eligible = req_valid & ~busy;

    // Search begins at the rr pointer and wraps; operands never influence the grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr, (TAG_W+1)'(k));
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign req_ready = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

    // Issue stage p0: operands and tag registered toward the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            rr_ptr <= '0;
            fma_a  <= '0;
            fma_b  <= '0;
            fma_c  <= '0;
        end else begin
            vld_p0 <= grant_any;
            if (grant_any) begin
                fma_a  <= req_a[grant_idx*DATA_W +: DATA_W];
                fma_b  <= req_b[grant_idx*DATA_W +: DATA_W];
                fma_c  <= req_c[grant_idx*DATA_W +: DATA_W];
                rr_ptr <= wrap_add(grant_idx, (TAG_W+1)'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) tag_p0 <= grant_idx;
    end

    assign fma_in_valid = vld_p0;

    generate
        if (LAT == 0) begin : g_comb_core
            assign cap_vld = vld_p0;
            assign cap_tag = tag_p0;
        end else begin : g_tag_pipe
            logic             vld_dly [LAT];
            logic [TAG_W-1:0] tag_dly [LAT];

            // Stages p1..pLAT track the core latency; the last one lines up with fma_result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < LAT; s++) vld_dly[s] <= 1'b0;
                end else begin
                    vld_dly[0] <= vld_p0;
                    for (int s = 1; s < LAT; s++) vld_dly[s] <= vld_dly[s-1];
                end
            end

            always_ff @(posedge clk) begin
                tag_dly[0] <= tag_p0;
                for (int s = 1; s < LAT; s++) tag_dly[s] <= tag_dly[s-1];
            end

            assign cap_vld = vld_dly[LAT-1];
            assign cap_tag = tag_dly[LAT-1];
        end
    endgenerate

    // Capture stage: result steered into the issuer's holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            busy       <= (busy | (req_valid & req_ready)) & ~(resp_valid & resp_ready);
            resp_valid <= resp_valid & ~resp_ready;
            if (cap_vld) begin
                resp_valid[cap_tag]                   <= 1'b1;
                resp_data[cap_tag*DATA_W +: DATA_W]   <= fma_result;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (!rst_n) cap_vld |-> busy[cap_tag]);
    assert property (@(posedge clk) disable iff (!rst_n) cap_vld |-> !resp_valid[cap_tag]);

endmodule

// File: tb/tb_fma_share_arbiter.sv
// Directed bench for fma_share_arbiter: a LAT=3 instance and a LAT=0 instance,
// each fed by a behavioural FP32 FMA core model.
module tb_fma_share_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            rst_n;

    logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [NR*32-1:0] req_a, req_b, req_c, resp_data;
    logic             fma_in_valid;
    logic [31:0]      fma_a, fma_b, fma_c, fma_result;

    logic [NR-1:0]    l0_req_valid, l0_req_ready, l0_resp_valid, l0_resp_ready;
    logic [NR*32-1:0] l0_req_a, l0_req_b, l0_req_c, l0_resp_data;
    logic             l0_fma_in_valid;
    logic [31:0]      l0_fma_a, l0_fma_b, l0_fma_c, l0_fma_result;

    int vectors;
    int miscompares;

    logic [31:0] fv      [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [3:0]  exp_rdy [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                 4'b0000, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0]  exp_rv  [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    fma_share_arbiter #(.NUM_REQ(NR), .LAT(3), .TAG_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fma_in_valid(fma_in_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_result(fma_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
    );

    fma_share_arbiter #(.NUM_REQ(NR), .LAT(0), .TAG_W(2)) dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l0_req_valid), .req_ready(l0_req_ready),
        .req_a(l0_req_a), .req_b(l0_req_b), .req_c(l0_req_c),
        .fma_in_valid(l0_fma_in_valid), .fma_a(l0_fma_a), .fma_b(l0_fma_b), .fma_c(l0_fma_c),
        .fma_result(l0_fma_result),
        .resp_valid(l0_resp_valid), .resp_ready(l0_resp_ready), .resp_data(l0_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fma(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    // Core models: three-stage pipeline for the LAT=3 instance, combinational for LAT=0.
    logic [31:0] core_pipe [3];
    always @(posedge clk) begin
        core_pipe[0] <= fma(fma_a, fma_b, fma_c);
        core_pipe[1] <= core_pipe[0];
        core_pipe[2] <= core_pipe[1];
    end
    assign fma_result = core_pipe[2];

    always_comb l0_fma_result = fma(l0_fma_a, l0_fma_b, l0_fma_c);

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_c[i*32 +: 32] = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_c = '0;
        l0_req_valid = '0; l0_resp_ready = '0; l0_req_a = '0; l0_req_b = '0; l0_req_c = '0;
        step(2);

        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_fma_in_valid", 32'(fma_in_valid), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_fma_a", fma_a, 32'h0);
        chk("rst_resp_data0", resp_data[31:0], 32'h0);
        rst_n = 1'b1;
        step(1);

        // Single op: 1.0 * 2.0 + 3.0
        set_ops(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step(1);
        req_valid = '0;
        chk("t1_fiv_T1", 32'(fma_in_valid), 32'h1);
        chk("t1_fma_a", fma_a, 32'h3F800000);
        chk("t1_fma_b", fma_b, 32'h40000000);
        chk("t1_fma_c", fma_c, 32'h40400000);
        step(1);
        chk("t1_fiv_T2", 32'(fma_in_valid), 32'h0);
        step(2);
        chk("t1_rv_T4", 32'(resp_valid), 32'h0);
        step(1);
        chk("t1_rv_T5", 32'(resp_valid), 32'h1);
        chk("t1_data", resp_data[31:0], 32'h40A00000);
        step(2);
        chk("t1_rv_hold", 32'(resp_valid), 32'h1);
        resp_ready = 4'b0001;
        step(1);
        resp_ready = '0;
        chk("t1_rv_drop", 32'(resp_valid), 32'h0);

        // Round robin from reset, all requesters, responses accepted immediately
        do_reset();
        for (int i = 0; i < NR; i++) set_ops(i, fv[i], 32'h3F800000, 32'h0);
        resp_ready = 4'hF;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t2_ready_k%0d", k), 32'(req_ready), 32'(exp_rdy[k]));
            chk($sformatf("t2_rv_k%0d", k), 32'(resp_valid), 32'(exp_rv[k]));
            if (k >= 1 && k <= 4) chk($sformatf("t2_fma_a_k%0d", k), fma_a, fv[k-1]);
            if (k >= 5) chk($sformatf("t2_data_k%0d", k), resp_data[(k-5)*32 +: 32], fv[k-5]);
            step(1);
        end
        req_valid = '0;
        step(8);
        chk("t2_drained", 32'(resp_valid), 32'h0);

        // Busy lockout with a held response
        do_reset();
        resp_ready = '0;
        set_ops(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        req_valid = 4'b0001;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'h1);
        step(1);
        chk("t3_locked_T1", 32'(req_ready), 32'h0);
        step(4);
        chk("t3_rv0", 32'(resp_valid[0]), 32'h1);
        chk("t3_data0", resp_data[31:0], 32'h40A00000);
        set_ops(1, 32'h40000000, 32'h40000000, 32'hBF800000);
        req_valid = 4'b0011;
        #1;
        chk("t3_ready1", 32'(req_ready), 32'h2);
        step(1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_lock_k%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("t3_rv0_k%0d", k), 32'(resp_valid[0]), 32'h1);
            chk($sformatf("t3_data0_k%0d", k), resp_data[31:0], 32'h40A00000);
            step(1);
        end
        chk("t3_data1", resp_data[63:32], 32'h40400000);
        resp_ready = 4'b0001;
        #1;
        chk("t3_same_cycle", 32'(req_ready), 32'h0);
        step(1);
        resp_ready = '0;
        chk("t3_rv0_cleared", 32'(resp_valid[0]), 32'h0);
        chk("t3_regrant", 32'(req_ready), 32'h1);
        step(1);
        req_valid = '0;

        // Fairness after skip: move rr pointer to 2, then req0 and req3 compete
        do_reset();
        resp_ready = 4'hF;
        req_valid = 4'b0010;
        #1;
        chk("t4_ready1", 32'(req_ready), 32'h2);
        step(1);
        req_valid = 4'b1001;
        #1;
        chk("t4_first", 32'(req_ready), 32'h8);
        step(1);
        chk("t4_second", 32'(req_ready), 32'h1);
        step(1);
        req_valid = '0;

        // Reset mid-flight
        do_reset();
        resp_ready = '0;
        for (int i = 0; i < 3; i++) set_ops(i, fv[i], 32'h40000000, 32'h3F800000);
        req_valid = 4'b0111;
        #1;
        step(3);
        req_valid = '0;
        chk("t5_fiv_last", 32'(fma_in_valid), 32'h1);
        chk("t5_fma_a_last", fma_a, 32'h40400000);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_fiv", 32'(fma_in_valid), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        chk("t5_rst_rv", 32'(resp_valid), 32'h0);
        chk("t5_rst_fma_a", fma_a, 32'h0);
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("t5_no_resp_k%0d", k), 32'(resp_valid), 32'h0);
        end

        // LAT=0 instance: back-to-back grants to req1 and req2
        l0_req_a[63:32]  = 32'h40000000;
        l0_req_b[63:32]  = 32'h40000000;
        l0_req_c[63:32]  = 32'hBF800000;
        l0_req_a[95:64]  = 32'h40400000;
        l0_req_b[95:64]  = 32'h3F800000;
        l0_req_c[95:64]  = 32'h3F800000;
        l0_req_valid = 4'b0110;
        #1;
        chk("t6_ready1", 32'(l0_req_ready), 32'h2);
        step(1);
        chk("t6_ready2", 32'(l0_req_ready), 32'h4);
        chk("t6_fiv", 32'(l0_fma_in_valid), 32'h1);
        chk("t6_fma_a", l0_fma_a, 32'h40000000);
        step(1);
        l0_req_valid = '0;
        chk("t6_rv_T2", 32'(l0_resp_valid), 32'h2);
        chk("t6_data1", l0_resp_data[63:32], 32'h40400000);
        step(1);
        chk("t6_rv_T3", 32'(l0_resp_valid), 32'h6);
        chk("t6_data2", l0_resp_data[95:64], 32'h40800000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fma_share_arbiter.md
Name: fma_share_arbiter

Overview:
- Shares one pipelined FP32 fused multiply-add datapath (result = a*b + c) between NUM_REQ requesters.
- Round-robin arbitration; at most one issue per cycle into the FMA pipe.
- Each issue carries a tag through a LAT-deep shift register; the returning result is steered into that requester's response holding register.
- Sits between requesting engines and the FMA core; the FMA core itself is external.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAT, 3, cycles from fma_in_valid to fma_result valid (0..8; 0 = combinational core).
- TAG_W, 2, tag width, = clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester grant; at most one bit high.
- req_a  input  NUM_REQ*32  operand a; slice i = [32*i+31:32*i].
- req_b  input  NUM_REQ*32  operand b, same slicing.
- req_c  input  NUM_REQ*32  addend c, same slicing.
- fma_in_valid  output  1  issue strobe to the FMA core.
- fma_a, fma_b, fma_c  output  32 each  registered operands to the core.
- fma_result  input  32  core result, valid exactly LAT cycles after fma_in_valid.
- resp_valid  output  NUM_REQ  response holding register i is full.
- resp_ready  input  NUM_REQ  requester i accepts its response.
- resp_data  output  NUM_REQ*32  response payload, same slicing as req_a.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - req_ready, fma_in_valid, resp_valid = 0.
  - fma_a/b/c, resp_data = 0.
  - busy[] = 0, tag pipe valid bits = 0, rr pointer = 0.
- busy[i] (registered):
  - Set on request handshake (req_valid[i] & req_ready[i]).
  - Cleared on response handshake (resp_valid[i] & resp_ready[i]).
  - Enforces one outstanding op per requester, so the holding register can never overflow and no backpressure reaches the FMA core.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i].
- Grant is combinational from eligible[] and the rr pointer:
  - Search starts at rr pointer and wraps; the first eligible index is granted.
  - req_ready = one-hot of the granted index, or all zero if none is eligible.
  - req_ready never depends on the sampled operand values.
- On handshake at cycle T:
  - fma_a/b/c <= requester operands; fma_in_valid = 1 in cycle T+1 only (single-cycle pulse).
  - tag and valid enter the tag pipe; rr pointer <= (granted+1) mod NUM_REQ.
- No handshake in a cycle: fma_in_valid = 0 next cycle, operand registers hold, rr pointer holds.
- Tag pipe is LAT stages aligned to fma_in_valid. When the stage-LAT output is valid:
  - fma_result is captured into resp_data[tag] and resp_valid[tag] is set at the next edge.
  - With LAT=0, capture occurs at the end of the fma_in_valid cycle.
- End-to-end latency: request handshake at T → resp_valid at T+2+LAT.
- Back-to-back: distinct requesters may issue on consecutive cycles; the pipe holds up to LAT+1 ops in flight.
- resp_valid[i] and resp_data[i] hold stable until resp_ready[i]; resp_valid[i] falls the cycle after the handshake.
- Simultaneous response handshake and new req_valid from the same requester in one cycle:
  - No grant that cycle, since busy is still 1.
  - Grant is possible the following cycle, with a 1-cycle bubble per requester.
- resp_ready with resp_valid = 0 is ignored.
- req_valid may drop without a handshake; no state changes.
- Reset mid-operation: all in-flight tags and holding registers are discarded; a stale fma_result after reset is ignored (tag valids = 0).
- Assertions:
  - $onehot0(req_ready).
  - A capture never targets a requester whose busy bit = 0.
  - A capture never targets a full holding register.

Test Plan:
- LAT=3, single op: req0 a=0x3F800000, b=0x40000000, c=0x40400000, behavioural FMA model → req_ready[0] same cycle; fma_in_valid one cycle later; resp_valid[0] at T+5; resp_data[0]=0x40A00000.
- Round-robin from reset: all 4 req_valid held high with resp_ready=1 → grants 0,1,2,3 on consecutive cycles; responses return in order 0,1,2,3 at T+5..T+8; each requester's second grant follows after its response handshake plus one cycle.
- Busy lockout: req0 completes with resp_ready[0]=0 for 10 cycles, req0 re-asserts valid → no req_ready[0] while resp_valid[0]=1; req1 still granted; resp_data[0] remains stable.
- Fairness after skip: rr pointer=2, only req0 and req3 valid → req3 granted first, then req0.
- Reset mid-flight: assert rst_n=0 two cycles after three issues → all outputs 0 immediately; after release no resp_valid rises from the discarded ops.
- LAT=0 build: a=0x40000000, b=0x40000000, c=0xBF800000 → resp_data=0x40400000 at T+2; back-to-back grants to req1 and req2 yield correct tags.
